// File: rtl/attn_inst_sequencer.sv
// attn_inst_sequencer: drives the fullchip instruction word for one attention
// pass (K load, Q/V execute, OFIFO->PMEM drain, PMEM readout). In IDLE the
// host instruction is passed straight through; while busy the sequencer owns
// inst and every output it drives comes from a register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | host_inst forwarded, waiting for a start with n in range
// S_LOAD  | col+2 cycles of load, K rows read for c = 1..col
// S_GAP1  | gap cycles of quiet inst after LOAD
// S_EXEC  | n cycles of execute + qmem_rd, qkmem_add = c
// S_GAP2  | gap cycles of quiet inst after EXEC
// S_DRAIN | n cycles of ofifo_rd + pmem_wr, pmem_add = c
// S_READ  | n+1 cycles; PMEM read for c < n, last cycle captures final row
// S_DONE  | one-cycle done pulse, then back to IDLE
module attn_inst_sequencer #(
  parameter logic [7:0] col         = 8'd8,
  parameter logic [7:0] total_cycle = 8'd8,
  parameter logic [9:0] gap         = 10'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [4:0]  n,
  input  logic [19:0] host_inst,
  output logic [19:0] inst,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [4:0]  out_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP1,
    S_EXEC,
    S_GAP2,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [9:0]  cnt;
  logic [9:0]  cnt_nx;
  logic [4:0]  n_q;
  logic [4:0]  n_nx;
  logic        mode_q;
  logic        mode_nx;
  logic [19:0] seq_inst_q;
  logic [19:0] seq_inst_nx;
  logic        busy_q;
  logic        done_q;
  logic        out_valid_q;
  logic        out_valid_nx;
  logic [4:0]  out_idx_q;
  logic [4:0]  out_idx_nx;

  logic        accept;
  logic [9:0]  load_last;
  logic [9:0]  gap_last;
  logic [9:0]  n_last;
  logic [9:0]  n_full;
  logic [4:0]  addr_m1;

  // start is only honoured for 1 <= n <= total_cycle; anything else is dropped
  assign accept    = start && (n != 5'd0) && ({3'b000, n} <= total_cycle);
  assign load_last = {2'b00, col} + 10'd1;
  assign gap_last  = gap - 10'd1;
  assign n_full    = {5'b00000, n_q};
  assign n_last    = n_full - 10'd1;
  assign addr_m1   = cnt_nx[4:0] - 5'd1;

  // Next-state and cycle counter; the counter restarts on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 10'd1;
    n_nx     = n_q;
    mode_nx  = mode_q;
    case (state)
      S_IDLE: begin
        cnt_nx = 10'd0;
        if (accept) begin
          state_nx = S_LOAD;
          n_nx     = n;
          mode_nx  = mode;
        end
      end
      S_LOAD: begin
        if (cnt == load_last) begin
          cnt_nx   = 10'd0;
          state_nx = (gap == 10'd0) ? S_EXEC : S_GAP1;
        end
      end
      S_GAP1: begin
        if (cnt == gap_last) begin
          cnt_nx   = 10'd0;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt == n_last) begin
          cnt_nx   = 10'd0;
          state_nx = (gap == 10'd0) ? S_DRAIN : S_GAP2;
        end
      end
      S_GAP2: begin
        if (cnt == gap_last) begin
          cnt_nx   = 10'd0;
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt == n_last) begin
          cnt_nx   = 10'd0;
          state_nx = S_READ;
        end
      end
      S_READ: begin
        if (cnt == n_full) begin
          cnt_nx   = 10'd0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        cnt_nx   = 10'd0;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = 10'd0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state/count so the registered outputs line
  // up with the state they describe
  always_comb begin
    seq_inst_nx  = 20'd0;
    out_valid_nx = 1'b0;
    out_idx_nx   = 5'd0;
    case (state_nx)
      S_LOAD: begin
        seq_inst_nx[6] = 1'b1;
        if ((cnt_nx != 10'd0) && (cnt_nx <= {2'b00, col})) begin
          seq_inst_nx[3]     = 1'b1;
          seq_inst_nx[17:13] = addr_m1;
        end
      end
      S_EXEC: begin
        seq_inst_nx[7]     = 1'b1;
        seq_inst_nx[5]     = 1'b1;
        seq_inst_nx[17:13] = cnt_nx[4:0];
      end
      S_DRAIN: begin
        seq_inst_nx[18]   = 1'b1;
        seq_inst_nx[0]    = 1'b1;
        seq_inst_nx[12:8] = cnt_nx[4:0];
      end
      S_READ: begin
        if (cnt_nx < {5'b00000, n_nx}) begin
          seq_inst_nx[1]    = 1'b1;
          seq_inst_nx[12:8] = cnt_nx[4:0];
          seq_inst_nx[19]   = mode_nx;
        end
        // PMEM read data trails the address by one cycle
        if (cnt_nx != 10'd0) begin
          out_valid_nx = 1'b1;
          out_idx_nx   = addr_m1;
        end
      end
      default: begin
      end
    endcase
  end

  // State, counter, latched pass parameters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 10'd0;
      n_q         <= 5'd0;
      mode_q      <= 1'b0;
      seq_inst_q  <= 20'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 5'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      n_q         <= n_nx;
      mode_q      <= mode_nx;
      seq_inst_q  <= seq_inst_nx;
      busy_q      <= (state_nx != S_IDLE);
      done_q      <= (state_nx == S_DONE);
      out_valid_q <= out_valid_nx;
      out_idx_q   <= out_idx_nx;
    end
  end

  assign inst      = (state == S_IDLE) ? host_inst : seq_inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_attn_inst_sequencer.sv
// Directed bench for attn_inst_sequencer with default parameters
// (col = 8, total_cycle = 8, gap = 10).
module tb_attn_inst_sequencer;

  localparam int COL = 8;
  localparam int GAP = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [4:0]  n;
  logic [19:0] host_inst;
  logic [19:0] inst;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [4:0]  out_idx;

  int checks = 0;
  int errors = 0;

  attn_inst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .n         (n),
    .host_inst (host_inst),
    .inst      (inst),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected inst at offset k after the accepting edge (k = 0 is first LOAD cycle)
  function automatic logic [19:0] exp_inst(input int k, input int nv, input logic mv);
    logic [19:0] v;
    int c;
    v = 20'd0;
    c = k;
    if (c < COL + 2) begin
      v[6] = 1'b1;
      if (c >= 1 && c <= COL) begin
        v[3] = 1'b1;
        v[17:13] = 5'(c - 1);
      end
      return v;
    end
    c -= COL + 2;
    if (c < GAP) return v;
    c -= GAP;
    if (c < nv) begin
      v[7] = 1'b1;
      v[5] = 1'b1;
      v[17:13] = 5'(c);
      return v;
    end
    c -= nv;
    if (c < GAP) return v;
    c -= GAP;
    if (c < nv) begin
      v[18] = 1'b1;
      v[0] = 1'b1;
      v[12:8] = 5'(c);
      return v;
    end
    c -= nv;
    if (c < nv) begin
      v[1] = 1'b1;
      v[12:8] = 5'(c);
      v[19] = mv;
    end
    return v;
  endfunction

  // Runs one pass starting from an idle, post-edge point in time.
  // pulse_at: offset at which start is re-pulsed with host_inst = FFFFF (-1 = never)
  // abort_at: offset at which reset is asserted (-1 = never)
  task automatic run_pass(input logic [4:0] nv, input logic mv, input int pulse_at,
                          input int abort_at, input int exp_done_at);
    int len;
    int rd;
    int done_at;
    int done_cnt;
    logic [19:0] e;
    len = COL + 2 + 2 * GAP + 3 * int'(nv) + 2;
    rd  = COL + 2 + 2 * GAP + 2 * int'(nv);
    done_at  = -1;
    done_cnt = 0;
    start = 1'b1;
    n     = nv;
    mode  = mv;
    @(posedge clk); #1;
    start = 1'b0;
    n     = 5'd1;
    mode  = ~mv;
    for (int k = 0; k < len; k++) begin
      e = exp_inst(k, int'(nv), mv);
      chk($sformatf("inst n=%0d k=%0d", nv, k), 32'(inst), 32'(e));
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
      chk($sformatf("done k=%0d", k), 32'(done), (k == len - 1) ? 32'd1 : 32'd0);
      if (k >= rd + 1 && k <= rd + int'(nv)) begin
        chk($sformatf("out_valid k=%0d", k), 32'(out_valid), 32'd1);
        chk($sformatf("out_idx k=%0d", k), 32'(out_idx), 32'(k - rd - 1));
      end else begin
        chk($sformatf("out_valid k=%0d", k), 32'(out_valid), 32'd0);
      end
      if (done === 1'b1) begin
        done_at = k;
        done_cnt++;
      end
      if (k == abort_at) begin
        reset     = 1'b0;
        host_inst = 20'h00000;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort out_idx", 32'(out_idx), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort inst zero", 32'(inst), 32'h00000);
        host_inst = 20'h00010;
        #1;
        chk("abort inst pass", 32'(inst), 32'h00010);
        @(posedge clk); #1;
        chk("abort held busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("after abort busy", 32'(busy), 32'd0);
        chk("after abort inst", 32'(inst), 32'h00010);
        return;
      end
      if (k == pulse_at) begin
        start     = 1'b1;
        host_inst = 20'hFFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done offset", 32'(done_at), 32'(exp_done_at));
    chk("done count", 32'(done_cnt), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle done", 32'(done), 32'd0);
    chk("idle inst passthrough", 32'(inst), 32'(host_inst));
    @(posedge clk); #1;
    chk("idle stays", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    n         = 5'd0;
    host_inst = 20'h00010;
    #1;
    chk("reset inst", 32'(inst), 32'h00010);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_idx", 32'(out_idx), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle inst qmem_wr", 32'(inst), 32'h00010);
    host_inst = 20'h0A5C3;
    #1;
    chk("idle inst comb", 32'(inst), 32'h0A5C3);

    // Score pass, n = 8: done on offset 55 (56-cycle pass)
    host_inst = 20'h12345;
    run_pass(5'd8, 1'b0, -1, -1, 55);

    // Norm-V pass, n = 3: 41-cycle pass, inst[19] during the 3 reads
    host_inst = 20'h00004;
    run_pass(5'd3, 1'b1, -1, -1, 40);

    // Out-of-range n is ignored
    host_inst = 20'h00020;
    start = 1'b1;
    n     = 5'd0;
    @(posedge clk); #1;
    chk("n=0 busy", 32'(busy), 32'd0);
    chk("n=0 inst", 32'(inst), 32'h00020);
    n = 5'd9;
    @(posedge clk); #1;
    chk("n=9 busy", 32'(busy), 32'd0);
    chk("n=9 inst", 32'(inst), 32'h00020);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bad n done %0d", i), 32'(done), 32'd0);
      chk($sformatf("bad n busy %0d", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // start re-pulsed during EXEC with host_inst all ones
    host_inst = 20'h00000;
    run_pass(5'd8, 1'b0, 22, -1, 55);
    host_inst = 20'h00000;

    // Reset during DRAIN c = 4 (offset 42), then a fresh n = 8 pass
    run_pass(5'd8, 1'b0, -1, 42, 55);
    host_inst = 20'h00008;
    run_pass(5'd8, 1'b0, -1, -1, 55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
